render_sequencer: RTL
=====================

Name: render_sequencer

Overview:
- Frame-level controller for the pixel-shader array; runs one frame on `start`.
- Sequences three passes:
  - rasterize: broadcast each voxel, pulse `do_rasterize`, wait for all shaders.
  - shade: broadcast each palette index/entry, pulse `do_shade`, wait for all shaders.
  - readout: scan row/col over the shared pixel bus and write the framebuffer.
- Sits between voxel memory, palette memory, the shader array and the framebuffer writer.

Parameters:
- ROWS, 4, shader array rows (pixel height)
- COLS, 4, shader array columns (pixel width)
- ROW_BITS, 8, row bus width
- COL_BITS, 8, col bus width
- COORD_BITS, 8, voxel coordinate width
- PALETTE_BITS, 8, voxel id / palette index width
- PIXEL_BITS, 8, pixel width
- VOXEL_ADDR_BITS, 10, voxel memory address width
- FB_ADDR_BITS, 16, framebuffer address width
- TIMEOUT, 255, max cycles waiting for a shader-array done

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin frame; sampled in IDLE only
- voxel_count  in  VOXEL_ADDR_BITS+1  voxels to rasterize; sampled at start
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse at frame end
- timeout_err  out  1  sticky; cleared on the next accepted start
- voxel_addr  out  VOXEL_ADDR_BITS  voxel memory read address
- voxel_rdata  in  3*COORD_BITS+PALETTE_BITS  {x,y,z,id}; valid 1 cycle after address
- palette_addr  out  PALETTE_BITS  palette read address
- palette_rdata  in  PIXEL_BITS  valid 1 cycle after address
- voxel_x, voxel_y, voxel_z  out  COORD_BITS each  broadcast to shaders
- voxel_id  out  PALETTE_BITS  broadcast to shaders
- palette_entry  out  PIXEL_BITS  broadcast to shaders
- do_rasterize  out  1  one-cycle pulse
- do_shade  out  1  one-cycle pulse
- rasterizing_done_all  in  1  AND of all shader rasterizing_done
- shading_done_all  in  1  AND of all shader shading_done
- row  out  ROW_BITS  shader select for pixel bus
- col  out  COL_BITS  shader select for pixel bus
- pixel  in  PIXEL_BITS  shared pixel bus
- fb_valid  out  1  framebuffer write request
- fb_ready  in  1  framebuffer accepts
- fb_addr  out  FB_ADDR_BITS  row*COLS+col
- fb_data  out  PIXEL_BITS  pixel value

Behaviour:
- Reset (reset=0, async):
  - state = IDLE.
  - All outputs 0, including pulses, broadcasts, row/col, fb_valid and timeout_err.
  - Reset mid-frame abandons the frame; no frame_done is issued.
- States: IDLE, V_FETCH, V_LOAD, RASTER, R_WAIT, P_FETCH, P_LOAD, SHADE, S_WAIT, RD_SEL, RD_WRITE, DONE.
- IDLE:
  - On start: latch voxel_count, clear the voxel index and timeout_err.
  - Go to V_FETCH if count≠0, else to P_FETCH (zero voxels skips rasterize).
  - start is ignored while busy.
- V_FETCH: voxel_addr = index. Next cycle, V_LOAD registers voxel_rdata into voxel_x/y/z/id.
- RASTER:
  - do_rasterize = 1 for exactly one cycle.
  - Broadcast registers are held stable until R_WAIT exits.
- R_WAIT:
  - Wait for rasterizing_done_all, then increment the index.
  - index == count → P_FETCH with palette index 0; otherwise → V_FETCH.
- Rasterize cost: minimum 4 cycles plus shader latency per voxel.
- P_FETCH / P_LOAD:
  - palette_addr = p.
  - Load voxel_id = p and palette_entry = palette_rdata; voxel_x/y/z hold their last value.
- SHADE: one-cycle do_shade.
- S_WAIT:
  - On shading_done_all: if p == 2^PALETTE_BITS−1 → RD_SEL with row=col=0; else p+1 → P_FETCH.
  - The p counter is one bit wider than PALETTE_BITS so the end test never wraps.
- RD_SEL: drive row/col for one cycle so the bus settles.
- RD_WRITE:
  - fb_valid=1, fb_data = pixel registered at the end of RD_SEL, fb_addr = row*COLS+col (zero-extended).
  - Hold fb_valid, fb_addr and fb_data stable until fb_ready. Transfer happens in the cycle where fb_valid && fb_ready.
  - Then advance col; at col == COLS−1 wrap col to 0 and increment row.
  - After (ROWS−1, COLS−1) → DONE; otherwise → RD_SEL.
- DONE: frame_done = 1 for one cycle → IDLE.
- Watchdog:
  - Counter is cleared on entry to R_WAIT/S_WAIT.
  - If the wait reaches TIMEOUT cycles: set timeout_err and proceed as if done.
  - done and timeout in the same cycle → treated as done; timeout_err is not set.
- Done inputs sampled outside R_WAIT/S_WAIT are ignored.

Test Plan:
- ROWS=COLS=2, voxel_count=3, done inputs return 2 cycles after each pulse:
  - required: exactly 3 do_rasterize pulses with voxel_addr 0,1,2 and matching broadcast data;
  - then 256 do_shade pulses with voxel_id 0..255;
  - then 4 fb writes at addr 0..3 carrying the selected pixel values;
  - then one frame_done; busy low afterwards.
- voxel_count=0 → no do_rasterize; first do_shade has voxel_id=0 and palette_entry = palette[0].
- fb_ready held low 5 cycles during write at addr 2 → fb_valid, fb_addr=2 and fb_data stable for all 5 cycles; single transfer; row/col unchanged.
- rasterizing_done_all stuck low, TIMEOUT=8 → exactly 8 wait cycles, then timeout_err=1 and the sequence continues; the next start clears timeout_err.
- start pulsed while busy → ignored; frame count unchanged.
- reset=0 during S_WAIT → busy, do_shade, fb_valid and row/col go to 0 immediately; no frame_done; a fresh start rasterizes from voxel 0.

Source files
------------

// File: rtl/render_sequencer.sv
// Frame controller for the pixel-shader array: rasterizes every voxel, shades every
// palette entry, then reads the shader pixels back out into the framebuffer.
module render_sequencer #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 8,
  parameter int COORD_BITS      = 8,
  parameter int PALETTE_BITS    = 8,
  parameter int PIXEL_BITS      = 8,
  parameter int VOXEL_ADDR_BITS = 10,
  parameter int FB_ADDR_BITS    = 16,
  parameter int TIMEOUT         = 255
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [VOXEL_ADDR_BITS:0]              voxel_count,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  timeout_err,
  output logic [VOXEL_ADDR_BITS-1:0]            voxel_addr,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0]  voxel_rdata,
  output logic [PALETTE_BITS-1:0]               palette_addr,
  input  logic [PIXEL_BITS-1:0]                 palette_rdata,
  output logic [COORD_BITS-1:0]                 voxel_x,
  output logic [COORD_BITS-1:0]                 voxel_y,
  output logic [COORD_BITS-1:0]                 voxel_z,
  output logic [PALETTE_BITS-1:0]               voxel_id,
  output logic [PIXEL_BITS-1:0]                 palette_entry,
  output logic                                  do_rasterize,
  output logic                                  do_shade,
  input  logic                                  rasterizing_done_all,
  input  logic                                  shading_done_all,
  output logic [ROW_BITS-1:0]                   row,
  output logic [COL_BITS-1:0]                   col,
  input  logic [PIXEL_BITS-1:0]                 pixel,
  output logic                                  fb_valid,
  input  logic                                  fb_ready,
  output logic [FB_ADDR_BITS-1:0]               fb_addr,
  output logic [PIXEL_BITS-1:0]                 fb_data
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] V_FETCH  = 4'd1;
  localparam logic [3:0] V_LOAD   = 4'd2;
  localparam logic [3:0] RASTER   = 4'd3;
  localparam logic [3:0] R_WAIT   = 4'd4;
  localparam logic [3:0] P_FETCH  = 4'd5;
  localparam logic [3:0] P_LOAD   = 4'd6;
  localparam logic [3:0] SHADE    = 4'd7;
  localparam logic [3:0] S_WAIT   = 4'd8;
  localparam logic [3:0] RD_SEL   = 4'd9;
  localparam logic [3:0] RD_WRITE = 4'd10;
  localparam logic [3:0] DONE     = 4'd11;

  localparam int WD_BITS = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // p carries one extra bit so the last-entry compare never wraps back to zero
  localparam logic [PALETTE_BITS:0] P_LAST = {1'b0, {PALETTE_BITS{1'b1}}};

  logic [3:0]                 state;
  logic [VOXEL_ADDR_BITS:0]   count;
  logic [VOXEL_ADDR_BITS:0]   idx;
  logic [PALETTE_BITS:0]      p;
  logic [WD_BITS-1:0]         wd;

  logic [VOXEL_ADDR_BITS:0]   idx_inc;
  logic [PALETTE_BITS:0]      p_inc;
  logic                       wait_expired;
  logic                       last_col;
  logic                       last_row;

  assign idx_inc      = idx + 1'b1;
  assign p_inc        = p + 1'b1;
  assign wait_expired = (wd == WD_BITS'(TIMEOUT - 1));
  assign last_col     = (col == COL_BITS'(COLS - 1));
  assign last_row     = (row == ROW_BITS'(ROWS - 1));
  assign busy         = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      idx           <= '0;
      p             <= '0;
      wd            <= '0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
      voxel_addr    <= '0;
      palette_addr  <= '0;
      voxel_x       <= '0;
      voxel_y       <= '0;
      voxel_z       <= '0;
      voxel_id      <= '0;
      palette_entry <= '0;
      do_rasterize  <= 1'b0;
      do_shade      <= 1'b0;
      row           <= '0;
      col           <= '0;
      fb_valid      <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
    end else begin
      do_rasterize <= 1'b0;
      do_shade     <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          count        <= voxel_count;
          idx          <= '0;
          p            <= '0;
          timeout_err  <= 1'b0;
          voxel_addr   <= '0;
          palette_addr <= '0;
          state        <= (voxel_count != '0) ? V_FETCH : P_FETCH;
        end
        V_FETCH: state <= V_LOAD;
        V_LOAD: begin
          voxel_x      <= voxel_rdata[3*COORD_BITS+PALETTE_BITS-1 -: COORD_BITS];
          voxel_y      <= voxel_rdata[2*COORD_BITS+PALETTE_BITS-1 -: COORD_BITS];
          voxel_z      <= voxel_rdata[COORD_BITS+PALETTE_BITS-1 -: COORD_BITS];
          voxel_id     <= voxel_rdata[PALETTE_BITS-1:0];
          do_rasterize <= 1'b1;
          state        <= RASTER;
        end
        RASTER: begin
          wd    <= '0;
          state <= R_WAIT;
        end
        R_WAIT: begin
          // a done arriving on the expiry cycle wins, so no error is flagged
          if (rasterizing_done_all || wait_expired) begin
            if (!rasterizing_done_all) timeout_err <= 1'b1;
            idx <= idx_inc;
            if (idx_inc == count) begin
              p            <= '0;
              palette_addr <= '0;
              state        <= P_FETCH;
            end else begin
              voxel_addr <= idx_inc[VOXEL_ADDR_BITS-1:0];
              state      <= V_FETCH;
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
        P_FETCH: state <= P_LOAD;
        P_LOAD: begin
          voxel_id      <= p[PALETTE_BITS-1:0];
          palette_entry <= palette_rdata;
          do_shade      <= 1'b1;
          state         <= SHADE;
        end
        SHADE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (shading_done_all || wait_expired) begin
            if (!shading_done_all) timeout_err <= 1'b1;
            if (p == P_LAST) begin
              row   <= '0;
              col   <= '0;
              state <= RD_SEL;
            end else begin
              p            <= p_inc;
              palette_addr <= p_inc[PALETTE_BITS-1:0];
              state        <= P_FETCH;
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RD_SEL: begin
          fb_data  <= pixel;
          fb_addr  <= FB_ADDR_BITS'(row) * FB_ADDR_BITS'(COLS) + FB_ADDR_BITS'(col);
          fb_valid <= 1'b1;
          state    <= RD_WRITE;
        end
        RD_WRITE: if (fb_ready) begin
          fb_valid <= 1'b0;
          if (!last_col) begin
            col   <= col + 1'b1;
            state <= RD_SEL;
          end else if (!last_row) begin
            col   <= '0;
            row   <= row + 1'b1;
            state <= RD_SEL;
          end else begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
